// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator (XGA 1024x768@60 by default) that sources the
// pixel-position stream for the draw chain, plus a frame-start pulse and a frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic [11:0] rgb,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_param_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // Region bounds are 12 bits wide so an end bound of exactly 2048 still compares correctly.
    localparam logic [11:0] H_BLNK_START = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_BLNK_START = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic        h_wrap;
    logic        frame_wrap;
    logic [10:0] hcount_next;
    logic [10:0] vcount_next;
    logic [11:0] h_ext;
    logic [11:0] v_ext;

    // Next counter values; the flags are decoded from these so they line up with the counters.
    always_comb begin
        h_wrap      = (hcount == H_LAST);
        frame_wrap  = h_wrap && (vcount == V_LAST);
        hcount_next = h_wrap ? 11'd0 : hcount + 11'd1;
        vcount_next = vcount;
        if (h_wrap) begin
            vcount_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end
        h_ext = {1'b0, hcount_next};
        v_ext = {1'b0, vcount_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            rgb         <= 12'h000;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            hcount      <= hcount_next;
            vcount      <= vcount_next;
            hblnk       <= (h_ext >= H_BLNK_START);
            hsync       <= (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
            vblnk       <= (v_ext >= V_BLNK_START);
            vsync       <= (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
            rgb         <= 12'h000;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunk-raster instance for full-frame behaviour and random
// resets, and a default XGA instance for the real horizontal timing of the first lines.
module tb_vga_timing_gen;

    // Shrunk raster: 25 pixels x 16 lines = 400 cycles per frame
    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 4;
    localparam int SVA = 10, SVF = 1, SVS = 2, SVB = 3;
    localparam int XHA = 1024, XHF = 24, XHS = 136, XHB = 160;
    localparam int XVA = 768, XVF = 3, XVS = 6, XVB = 29;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s = 1'b1;
    logic rst_x = 1'b1;

    logic [10:0] s_hcount, s_vcount, x_hcount, x_vcount;
    logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_frame_start;
    logic        x_hsync, x_vsync, x_hblnk, x_vblnk, x_frame_start;
    logic [11:0] s_rgb, x_rgb;
    logic [15:0] s_frame_cnt, x_frame_cnt;

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut (
        .clk(clk), .rst(rst_s),
        .hcount(s_hcount), .vcount(s_vcount),
        .hsync(s_hsync), .vsync(s_vsync), .hblnk(s_hblnk), .vblnk(s_vblnk),
        .rgb(s_rgb), .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
    );

    vga_timing_gen dut_xga (
        .clk(clk), .rst(rst_x),
        .hcount(x_hcount), .vcount(x_vcount),
        .hsync(x_hsync), .vsync(x_vsync), .hblnk(x_hblnk), .vblnk(x_vblnk),
        .rgb(x_rgb), .frame_start(x_frame_start), .frame_cnt(x_frame_cnt)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    bit     chk_en   = 1'b0;
    longint t_s      = 0;
    longint t_x      = 0;
    longint cyc      = 0;
    longint fs_last  = -1;
    longint fs_prev  = -1;
    int     n_fs     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv)
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        else
            n_pass++;
    endtask

    // Expected outputs purely from elapsed cycles since reset release (t=0 is the reset state).
    function automatic exp_t model(input longint t, input int ha, hf, hs, hb, va, vf, vs, vb);
        exp_t   m;
        longint ht, vt, ft, h, v;
        ht   = ha + hf + hs + hb;
        vt   = va + vf + vs + vb;
        ft   = ht * vt;
        h    = t % ht;
        v    = (t / ht) % vt;
        m.h  = 11'(h);
        m.v  = 11'(v);
        m.hb = (h >= ha);
        m.hs = (h >= ha + hf) && (h < ha + hf + hs);
        m.vb = (v >= va);
        m.vs = (v >= va + vf) && (v < va + vf + vs);
        m.fs = (t != 0) && (t % ft == 0);
        m.fc = 16'((t / ft) % 65536);
        return m;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e,
                           input logic [10:0] h, input logic [10:0] v,
                           input logic hs, input logic vs, input logic hb, input logic vb,
                           input logic [11:0] rgb, input logic fs, input logic [15:0] fc);
        check({tag, ".hcount"}, 64'(h), 64'(e.h));
        check({tag, ".vcount"}, 64'(v), 64'(e.v));
        check({tag, ".hsync"}, 64'(hs), 64'(e.hs));
        check({tag, ".vsync"}, 64'(vs), 64'(e.vs));
        check({tag, ".hblnk"}, 64'(hb), 64'(e.hb));
        check({tag, ".vblnk"}, 64'(vb), 64'(e.vb));
        check({tag, ".rgb"}, 64'(rgb), 64'd0);
        check({tag, ".frame_start"}, 64'(fs), 64'(e.fs));
        check({tag, ".frame_cnt"}, 64'(fc), 64'(e.fc));
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        t_s <= rst_s ? 0 : t_s + 1;
        t_x <= rst_x ? 0 : t_x + 1;
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_out("s", model(t_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB),
                    s_hcount, s_vcount, s_hsync, s_vsync, s_hblnk, s_vblnk,
                    s_rgb, s_frame_start, s_frame_cnt);
            cmp_out("x", model(t_x, XHA, XHF, XHS, XHB, XVA, XVF, XVS, XVB),
                    x_hcount, x_vcount, x_hsync, x_vsync, x_hblnk, x_vblnk,
                    x_rgb, x_frame_start, x_frame_cnt);
        end
        if (s_frame_start === 1'b1) begin
            fs_prev = fs_last;
            fs_last = cyc;
            n_fs++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_s = 1'b1;
        rst_x = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.hcount", 64'(s_hcount), 64'd0);
        check("reset.frame_cnt", 64'(s_frame_cnt), 64'd0);
        check("reset.xga_vcount", 64'(x_vcount), 64'd0);
        rst_s = 1'b0;
        rst_x = 1'b0;
        @(negedge clk);
        check("release.hcount", 64'(s_hcount), 64'd1);
        check("release.vcount", 64'(s_vcount), 64'd0);
        check("release.frame_start", 64'(s_frame_start), 64'd0);
        check("release.xga_hcount", 64'(x_hcount), 64'd1);

        fork
            begin : small_branch
                int vs_cnt;
                int vb_cnt;
                vs_cnt = 0;
                vb_cnt = 0;
                // t = 1 already observed; cover t = 1..400 for one full frame of sync counts
                for (int i = 0; i < 400; i++) begin
                    if (i > 0) @(negedge clk);
                    vs_cnt += (s_vsync === 1'b1) ? 1 : 0;
                    vb_cnt += (s_vblnk === 1'b1) ? 1 : 0;
                end
                check("small.vsync_cycles", 64'(vs_cnt), 64'd50);
                check("small.vblnk_cycles", 64'(vb_cnt), 64'd150);
                check("small.first_wrap_fs", 64'(s_frame_start), 64'd1);
                check("small.first_wrap_hcount", 64'(s_hcount), 64'd0);
                check("small.first_wrap_cnt", 64'(s_frame_cnt), 64'd1);
                repeat (600) @(negedge clk);
                check("small.pulse_count", 64'(n_fs), 64'd2);
                check("small.frame_period", 64'(fs_last - fs_prev), 64'd400);
                check("small.frame_cnt_2", 64'(s_frame_cnt), 64'd2);
                // Random run lengths with resets landing anywhere in the frame
                for (int k = 0; k < 8; k++) begin
                    repeat ($urandom_range(600, 30)) @(negedge clk);
                    rst_s = 1'b1;
                    repeat ($urandom_range(3, 1)) @(negedge clk);
                    check("small.rst_frame_cnt", 64'(s_frame_cnt), 64'd0);
                    rst_s = 1'b0;
                end
                repeat (450) @(negedge clk);
            end
            begin : xga_branch
                int hs_cnt;
                int hb_cnt;
                hs_cnt = 0;
                hb_cnt = 0;
                for (int i = 0; i < 1343; i++) begin
                    if (i > 0) @(negedge clk);
                    hs_cnt += (x_hsync === 1'b1) ? 1 : 0;
                    hb_cnt += (x_hblnk === 1'b1) ? 1 : 0;
                end
                check("xga.hsync_cycles", 64'(hs_cnt), 64'd136);
                check("xga.hblnk_cycles", 64'(hb_cnt), 64'd320);
                @(negedge clk);
                check("xga.wrap_hcount", 64'(x_hcount), 64'd0);
                check("xga.wrap_vcount", 64'(x_vcount), 64'd1);
                check("xga.wrap_hblnk", 64'(x_hblnk), 64'd0);
                repeat (1344 + $urandom_range(1343, 0)) @(negedge clk);
                rst_x = 1'b1;
                @(negedge clk);
                rst_x = 1'b0;
                @(negedge clk);
                check("xga.recover_hcount", 64'(x_hcount), 64'd1);
                check("xga.recover_fs", 64'(x_frame_start), 64'd0);
                repeat (1400) @(negedge clk);
            end
        join

        chk_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
